// File: rtl/bitbrick_seq_mac_if.sv
// rtl/bitbrick_seq_mac_if.sv - operand request and result handshake bundle for bitbrick_seq_mac
interface bitbrick_seq_mac_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_a_signed;
  logic             in_b_signed;
  logic [1:0]       in_prec;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_result;

  modport master (
    output in_valid, in_a, in_b, in_a_signed, in_b_signed, in_prec, in_acc, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_a, in_b, in_a_signed, in_b_signed, in_prec, in_acc, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/bitbrick_seq_mac.sv
// rtl/bitbrick_seq_mac.sv - sequences 2-bit operand bricks through one external bitbrick into a MAC accumulator
module bitbrick_seq_mac #(
  parameter int ACC_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  bitbrick_seq_mac_if.slave   io,
  output logic [1:0]          bb_a,
  output logic [1:0]          bb_b,
  output logic [1:0]          bb_sel,
  input  logic [3:0]          bb_p,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [3:0]       k;
  logic [7:0]       a_r, b_r;
  logic             as_r, bs_r;
  logic [1:0]       prec_r;

  logic [1:0]       bi, bj, top;
  logic [3:0]       k_last;
  logic [1:0]       ai, bjv;
  logic             a_sgn, b_sgn;
  logic [3:0]       sh;
  logic [ACC_W-1:0] p_ext, addend;

  // Counter splits into inner A index (low bits) and outer B index (high bits).
  always_comb begin
    bi     = 2'd0;
    bj     = 2'd0;
    top    = 2'd0;
    k_last = 4'd0;
    case (prec_r)
      2'b00: begin
        bi     = 2'd0;
        bj     = 2'd0;
        top    = 2'd0;
        k_last = 4'd0;
      end
      2'b01: begin
        bi     = {1'b0, k[0]};
        bj     = {1'b0, k[1]};
        top    = 2'd1;
        k_last = 4'd3;
      end
      default: begin
        bi     = k[1:0];
        bj     = k[3:2];
        top    = 2'd3;
        k_last = 4'd15;
      end
    endcase
  end

  assign ai    = a_r[{bi, 1'b0} +: 2];
  assign bjv   = b_r[{bj, 1'b0} +: 2];
  assign a_sgn = as_r && (bi == top);
  assign b_sgn = bs_r && (bj == top);
  assign sh    = {1'b0, bi, 1'b0} + {1'b0, bj, 1'b0};

  // The bitbrick only has a signed-A mode, so unsigned-A x signed-B swaps operands.
  always_comb begin
    bb_a   = 2'b00;
    bb_b   = 2'b00;
    bb_sel = 2'b01;
    if (state == RUN) begin
      case ({a_sgn, b_sgn})
        2'b00: begin bb_a = ai;  bb_b = bjv; bb_sel = 2'b01; end
        2'b11: begin bb_a = ai;  bb_b = bjv; bb_sel = 2'b00; end
        2'b10: begin bb_a = ai;  bb_b = bjv; bb_sel = 2'b10; end
        default: begin bb_a = bjv; bb_b = ai; bb_sel = 2'b10; end
      endcase
    end
  end

  assign p_ext  = (bb_sel == 2'b01) ? {{(ACC_W-4){1'b0}}, bb_p} : {{(ACC_W-4){bb_p[3]}}, bb_p};
  assign addend = p_ext << sh;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.in_valid) state_nx = RUN;
      RUN:     if (k == k_last) state_nx = DONE;
      DONE:    if (io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      k      <= 4'd0;
      a_r    <= 8'd0;
      b_r    <= 8'd0;
      as_r   <= 1'b0;
      bs_r   <= 1'b0;
      prec_r <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_r    <= io.in_a;
            b_r    <= io.in_b;
            as_r   <= io.in_a_signed;
            bs_r   <= io.in_b_signed;
            prec_r <= io.in_prec;
            acc    <= io.in_acc ? acc : '0;
            k      <= 4'd0;
          end
        end
        RUN: begin
          acc <= acc + addend;
          k   <= k + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready   = (state == IDLE);
  assign io.out_valid  = (state == DONE);
  assign io.out_result = acc;
  assign busy          = (state == RUN) || (state == DONE);

endmodule
